// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO: read-mode encoding,
// count-width helper and the almost-full/almost-empty level legality check.
package fifo_pkg;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_COUNT_WIDTH = DEF_ADDR_WIDTH + 1;

  // Occupancy spans 0..DEPTH inclusive, so it needs one bit more than a pointer.
  function automatic int unsigned count_width(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic logic levels_legal(input int unsigned ae,
                                        input int unsigned af,
                                        input int unsigned depth);
    return (ae > 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram_2p
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// overflow/underflow and selectable standard or first-word-fall-through reads.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = count_width(ADDR_WIDTH);
  localparam rd_mode_e    MODE  = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  if (!levels_legal(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_levels
    $error("sync_fifo_flags: need 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = rd_en && !w_empty;
  // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
  assign w_wr_ok = wr_en && (!w_full || w_rd_ok);

  fifo_ram_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  if (MODE == RD_STANDARD) begin : g_std_read
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_out <= '0;
      end else if (w_rd_ok) begin
        r_data_out <= w_rd_data;
      end
    end

    assign data_out = r_data_out;
  end else begin : g_fwft_read
    // Head word is presented directly; zero while empty keeps the output deterministic.
    assign data_out = w_empty ? '0 : w_rd_data;
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: standard and FWFT instances share stimulus
// and are compared each cycle against a queue model, plus literal spot checks.
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] d0_out, d1_out;
  logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [4:0] d0_count, d1_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2),
    .FWFT       (0)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .data_in (data_in),
    .rd_en (rd_en), .data_out (d0_out), .full (d0_full), .empty (d0_empty),
    .almost_full (d0_af), .almost_empty (d0_ae), .count (d0_count),
    .overflow (d0_ovf), .underflow (d0_unf), .err_clr (err_clr)
  );

  sync_fifo_flags #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2),
    .FWFT       (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .data_in (data_in),
    .rd_en (rd_en), .data_out (d1_out), .full (d1_full), .empty (d1_empty),
    .almost_full (d1_af), .almost_empty (d1_ae), .count (d1_count),
    .overflow (d1_ovf), .underflow (d1_unf), .err_clr (err_clr)
  );

  // Reference: contents as a queue, registered read word, sticky error bits.
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_rd_ok, m_wr_ok;
  int         m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_rd_ok = rd_en && (q.size() > 0);
      m_wr_ok = wr_en && ((q.size() < DEPTH) || m_rd_ok);
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (wr_en && !m_wr_ok) m_ovf = 1'b1;
        if (rd_en && !m_rd_ok) m_unf = 1'b1;
      end
      if (m_rd_ok) m_dout = q.pop_front();
      if (m_wr_ok) q.push_back(data_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      m_n = q.size();
      chk("count_std",  32'(d0_count), 32'(m_n));
      chk("count_fwft", 32'(d1_count), 32'(m_n));
      chk("full_std",   32'(d0_full),  32'(m_n == DEPTH));
      chk("full_fwft",  32'(d1_full),  32'(m_n == DEPTH));
      chk("empty_std",  32'(d0_empty), 32'(m_n == 0));
      chk("empty_fwft", 32'(d1_empty), 32'(m_n == 0));
      chk("af_std",     32'(d0_af),    32'(m_n >= 14));
      chk("af_fwft",    32'(d1_af),    32'(m_n >= 14));
      chk("ae_std",     32'(d0_ae),    32'(m_n <= 2));
      chk("ae_fwft",    32'(d1_ae),    32'(m_n <= 2));
      chk("ovf_std",    32'(d0_ovf),   32'(m_ovf));
      chk("ovf_fwft",   32'(d1_ovf),   32'(m_ovf));
      chk("unf_std",    32'(d0_unf),   32'(m_unf));
      chk("unf_fwft",   32'(d1_unf),   32'(m_unf));
      chk("dout_std",   32'(d0_out),   32'(m_dout));
      if (m_n > 0) chk("dout_fwft", 32'(d1_out), 32'(q[0]));
    end
  end

  // One clock cycle of stimulus; returns on the following falling edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    err_clr = c;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_count", 32'(d0_count), 0);
    chk("rst_empty", 32'(d0_empty), 1);
    chk("rst_full",  32'(d0_full),  0);
    chk("rst_ae",    32'(d0_ae),    1);
    chk("rst_af",    32'(d0_af),    0);
    chk("rst_dout",  32'(d0_out),   0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) chk("af_at13", 32'(d0_af), 0);
      if (i == 13) chk("af_at14", 32'(d0_af), 1);
    end
    chk("fill_full",  32'(d0_full),  1);
    chk("fill_count", 32'(d0_count), 16);

    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set",   32'(d0_ovf),   1);
    chk("ovf_count", 32'(d0_count), 16);
    cyc(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("clr_beats_ovf", 32'(d1_ovf), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_dout", 32'(d0_out), 32'(i));
      if (i == 12) chk("ae_at3", 32'(d0_ae), 0);
      if (i == 13) chk("ae_at2", 32'(d0_ae), 1);
    end
    chk("drain_empty", 32'(d0_empty), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set",   32'(d0_unf), 1);
    chk("unf_hold",  32'(d0_out), 32'h0F);

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr", 32'(d0_unf), 0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("rw_empty_count", 32'(d0_count), 1);
    chk("rw_empty_unf",   32'(d0_unf),   1);
    chk("rw_empty_fwft",  32'(d1_out),   32'h5A);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_5a", 32'(d0_out), 32'h5A);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_show",  32'(d1_out),   32'hA5);
    chk("fwft_nempt", 32'(d1_empty), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(d1_empty), 1);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h30, 1'b1, 1'b0);
    chk("rw_full_count", 32'(d0_count), 16);
    chk("rw_full_full",  32'(d0_full),  1);
    chk("rw_full_ovf",   32'(d0_ovf),   0);
    chk("rw_full_dout",  32'(d0_out),   32'h20);
    chk("rw_full_head",  32'(d1_out),   32'h21);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rw_full_last", 32'(d0_out), 32'h30);

    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h40 + b * 5 + k), 1'b0, 1'b0);
      chk("wrap_count", 32'(d0_count), 5);
      for (int k = 0; k < 5; k++) begin
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_dout", 32'(d0_out), 32'(8'h40 + b * 5 + k));
      end
    end

    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_unf", 32'(d0_unf), 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(d0_count), 7);
    wr_en   = 1'b1;
    data_in = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(d0_count), 0);
    chk("arst_empty", 32'(d0_empty), 1);
    chk("arst_unf",   32'(d0_unf),   0);
    chk("arst_ae",    32'(d1_ae),    1);
    chk("arst_dout",  32'(d0_out),   0);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_count", 32'(d1_count), 0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("post_rst_wr", 32'(d0_count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_rd", 32'(d0_out), 32'h99);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised next-generation synchronous FIFO: single clock, power-of-two depth, full-capacity storage.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and consumer in the same clock domain, as a drop-in buffer for datapath and bus-bridge blocks.

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries, all usable.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read/pop request.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- err_clr  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst_n low, async): pointers = 0, count = 0, data_out = 0, overflow = underflow = 0. Outputs after reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0. Storage contents are not reset.
- Accepted write: wr_ok = wr_en && (!full || rd_ok). Accepted read: rd_ok = rd_en && !empty.
- On wr_ok: mem[wr_ptr] <= data_in, wr_ptr increments modulo DEPTH (natural wrap).
- On rd_ok: rd_ptr increments modulo DEPTH.
- count is a registered counter:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
  - Never exceeds DEPTH and never goes below 0.
  - All flags decode combinationally from count.
- Simultaneous operations:
  - Read and write when full: both accepted, count stays DEPTH.
  - Read and write when empty: write accepted, read rejected, underflow set, count becomes 1.
- Standard mode (FWFT = 0): on rd_ok, data_out <= mem[rd_ptr] (one-cycle latency). data_out holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT = 1): data_out = mem[rd_ptr] combinationally whenever !empty, so the head word is visible with no read. rd_en acknowledges and pops it. A word written into an empty FIFO appears on data_out the cycle after the write. Value is don't-care when empty.
- Error flags:
  - overflow set on wr_en && !wr_ok; underflow set on rd_en && !rd_ok.
  - Both stay set until err_clr or reset.
  - err_clr has priority over a same-cycle set.
- Rejected operations change no pointer, count or storage.
- Reset mid-operation discards all contents immediately; no in-flight write completes.
- Parameter legality (checked by elaboration-time assertion): 0 < AE_LEVEL < AF_LEVEL <= DEPTH.

Decomposition:
- Shared package fifo_pkg holds the flag-level check function and a count width constant (ADDR_WIDTH+1).
- One sub-module, fifo_ram_2p: register array with one synchronous write port and one asynchronous read port, parametrised on DATA_WIDTH/ADDR_WIDTH.
- The top level holds pointers, count, flags and the read-mode logic.

Test Plan:
- Reset, then write 16 words 0x00..0x0F (DEPTH = 16) -> full = 1 and count = 16 after the 16th write. almost_full first asserts after the 14th write. A 17th write sets overflow and leaves count at 16.
- From full, read 16 words (FWFT = 0) -> data_out = 0x00..0x0F, each one cycle after its rd_en. empty = 1 after the last read. almost_empty asserts at count = 2. An extra read sets underflow and data_out holds 0x0F.
- Pointer wrap: 40 cycles of alternating write/read bursts of 5 -> data order is preserved across the wrap and count never exceeds 5.
- Simultaneous rd_en + wr_en when full -> count stays 16, full stays 1, no overflow. When empty -> count = 1, underflow = 1.
- FWFT = 1: write 0xA5 into an empty FIFO -> data_out = 0xA5 the next cycle with no rd_en. rd_en pops it and empty = 1 next cycle.
- Assert rst_n low mid-burst at count = 7 -> count = 0, empty = 1, flags cleared immediately (asynchronously). err_clr held together with a failing write -> overflow remains 0.
